// File: rtl/mem_io_responder_pkg.sv
// Shared constants, decode helpers and default sizes for the CPU-side memory/IO responder.
package mem_io_responder_pkg;

    // Default sizing
    localparam int unsigned RAM_ADDR_W_DEF  = 17;
    localparam int unsigned TX_DEPTH_DEF    = 16;
    localparam int unsigned RX_DEPTH_DEF    = 16;
    localparam int unsigned FULL_MARGIN_DEF = 2;

    // Decode field positions: only mem_a[17:0] is looked at
    localparam int unsigned DEC_W     = 18;
    localparam int unsigned IO_SEL_HI = 17;
    localparam int unsigned IO_SEL_LO = 16;

    // IO window and register offsets inside it
    localparam logic [DEC_W-1:0] IO_BASE = 18'h30000;
    localparam logic [15:0]      IO_UART = 16'd0;
    localparam logic [15:0]      IO_CLK  = 16'd4;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_IO,
        RGN_NONE
    } region_e;

    // Which register feeds cpu_din after the last accepted access
    typedef enum logic {
        SRC_IO,
        SRC_RAM
    } rd_src_e;

    function automatic region_e decode_region(input logic [DEC_W-1:0] a);
        if (a[IO_SEL_HI:IO_SEL_LO] == 2'b11) return RGN_IO;
        if (!a[IO_SEL_HI])                   return RGN_RAM;
        return RGN_NONE;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide synchronous FIFO; a pop on empty is ignored and a push on full lands
// only when a real pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    buf_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop, do_push;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : buf_q[rd_q];

    // Next pointers and occupancy
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents need no reset because dout is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_q] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: on-chip RAM with registered read, UART TX/RX
// FIFOs, free-running cycle counter with coherent snapshot, and program-stop flag.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W  = RAM_ADDR_W_DEF,
    parameter int unsigned TX_DEPTH    = TX_DEPTH_DEF,
    parameter int unsigned RX_DEPTH    = RX_DEPTH_DEF,
    parameter int unsigned FULL_MARGIN = FULL_MARGIN_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop
);
    localparam int unsigned TXC_W = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RXC_W = $clog2(RX_DEPTH) + 1;
    localparam logic [TXC_W-1:0] TX_FULL_LVL = TXC_W'(TX_DEPTH - FULL_MARGIN);

    logic [DEC_W-1:0] a;
    logic [15:0]      io_off;
    region_e          rgn;
    logic             acc;
    logic             unused_hi;

    assign a         = mem_a[DEC_W-1:0];
    assign io_off    = a[15:0];
    assign rgn       = decode_region(a);
    assign acc       = rdy_in;
    assign unused_hi = ^mem_a[31:DEC_W];

    logic io_wr, io_rd, ram_we, ram_re;
    assign io_wr  = acc &  mem_wr & (rgn == RGN_IO);
    assign io_rd  = acc & ~mem_wr & (rgn == RGN_IO);
    assign ram_we = acc &  mem_wr & (rgn == RGN_RAM);
    assign ram_re = acc & ~mem_wr & (rgn == RGN_RAM);

    // FIFO hookups
    logic             tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0]       tx_din;
    logic [TXC_W-1:0] tx_count;
    logic             rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]       rx_dout;
    logic [RXC_W-1:0] rx_count_unused;
    logic             stop_set;

    assign stop_set = io_wr & (io_off == IO_CLK);
    assign tx_push  = (io_wr & (io_off == IO_UART) & (cpu_dout != 8'h00)) | stop_set;
    assign tx_din   = stop_set ? 8'h00 : cpu_dout;
    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;

    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = io_rd & (io_off == IO_UART);

    assign io_buffer_full = (tx_count >= TX_FULL_LVL);

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (tx_din),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count_unused)
    );

    // RAM and its read register live in a reset-free block so the array infers as memory
    logic [7:0] ram_q [2**RAM_ADDR_W];
    logic [7:0] ram_rd_q;

    // RAM write and registered read
    always_ff @(posedge clk_in) begin
        if (ram_we) ram_q[a[RAM_ADDR_W-1:0]] <= cpu_dout;
        if (ram_re) ram_rd_q <= ram_q[a[RAM_ADDR_W-1:0]];
    end

    // cpu_din is a registered source select over the RAM read register and the IO
    // read register; both only advance on accepted accesses, so a stall holds cpu_din.
    rd_src_e     src_q, src_d;
    logic [7:0]  io_rd_q, io_rd_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] cnt_q;
    logic        stop_pending_q, stop_pending_d;
    logic        prog_stop_q, prog_stop_d;

    assign cpu_din   = (src_q == SRC_RAM) ? ram_rd_q : io_rd_q;
    assign prog_stop = prog_stop_q;

    // Read-data selection, snapshot capture and stop tracking
    always_comb begin
        src_d          = src_q;
        io_rd_d        = io_rd_q;
        snap_d         = snap_q;
        stop_pending_d = stop_pending_q | stop_set;
        prog_stop_d    = prog_stop_q | (stop_pending_q & tx_empty);
        if (acc) begin
            src_d   = SRC_IO;
            io_rd_d = '0;
            if (ram_re) begin
                src_d = SRC_RAM;
            end else if (io_rd) begin
                if (io_off == IO_UART) begin
                    io_rd_d = rx_dout;
                end else if (io_off == IO_CLK) begin
                    io_rd_d = cnt_q[7:0];
                    snap_d  = cnt_q;
                end else if (io_off == IO_CLK + 16'd1) begin
                    io_rd_d = snap_q[15:8];
                end else if (io_off == IO_CLK + 16'd2) begin
                    io_rd_d = snap_q[23:16];
                end else if (io_off == IO_CLK + 16'd3) begin
                    io_rd_d = snap_q[31:24];
                end
            end
        end
    end

    // Control/status registers and free-running cycle counter
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            src_q          <= SRC_IO;
            io_rd_q        <= '0;
            snap_q         <= '0;
            cnt_q          <= '0;
            stop_pending_q <= 1'b0;
            prog_stop_q    <= 1'b0;
        end else begin
            src_q          <= src_d;
            io_rd_q        <= io_rd_d;
            snap_q         <= snap_d;
            cnt_q          <= cnt_q + 32'd1;
            stop_pending_q <= stop_pending_d;
            prog_stop_q    <= prog_stop_d;
        end
    end

endmodule
